// File: rtl/ibex_rf_checkpoint.sv
// rtl/ibex_rf_checkpoint.sv - register-file save/restore streaming engine
module ibex_rf_checkpoint #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 save_req_i,
    input  logic                 restore_req_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [4:0]           out_addr_o,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i
);

    // Highest register index transferred; the pointer is one bit wider so
    // that it can step past x31 without wrapping back into range.
    localparam logic [5:0] Last = RV32E ? 6'd15 : 6'd31;

    typedef enum logic [1:0] {
        Idle,
        Save,
        Restore
    } state_e;

    state_e               state_q, state_d;
    logic [5:0]           ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [4:0]           out_addr_q, out_addr_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic                 done_q, done_d;
    logic                 load;
    logic                 out_hs;

    // Next-state logic: request arbitration, save output-register loading,
    // restore write counting, and abort override.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        load        = 1'b0;
        out_hs      = out_valid_q & out_ready_i;

        unique case (state_q)
            Idle: begin
                if (save_req_i) begin
                    state_d = Save;
                    ptr_d   = 6'd1;
                end else if (restore_req_i) begin
                    state_d = Restore;
                    ptr_d   = 6'd1;
                end
            end
            Save: begin
                load = (ptr_q <= Last) && (!out_valid_q || out_ready_i);
                if (load) begin
                    out_data_d  = rf_rdata_i;
                    out_addr_d  = ptr_q[4:0];
                    out_valid_d = 1'b1;
                    ptr_d       = ptr_q + 6'd1;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
                if (out_hs && (out_addr_q == Last[4:0])) begin
                    state_d = Idle;
                    done_d  = 1'b1;
                end
            end
            Restore: begin
                if (in_valid_i) begin
                    ptr_d = ptr_q + 6'd1;
                    if (ptr_q == Last) begin
                        state_d = Idle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase

        if (abort_i && (state_q != Idle)) begin
            state_d     = Idle;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= Idle;
            ptr_q       <= 6'd0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 5'd0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = (state_q != Idle);
    assign done_o      = done_q;
    assign rf_raddr_o  = (state_q == Save) ? ptr_q[4:0] : 5'd0;
    assign in_ready_o  = (state_q == Restore);
    assign rf_we_o     = in_valid_i & in_ready_o;
    assign rf_waddr_o  = in_ready_o ? ptr_q[4:0] : 5'd0;
    assign rf_wdata_o  = in_ready_o ? in_data_i : '0;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_ibex_rf_checkpoint.sv
// tb/tb_ibex_rf_checkpoint.sv - self-checking bench for ibex_rf_checkpoint
module tb_ibex_rf_checkpoint;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, save_req, restore_req, abort, out_ready, in_valid;
    logic [31:0] in_data, rf_rdata, rf_wdata, out_data;
    logic [4:0]  rf_raddr, rf_waddr, out_addr;
    logic        busy, done, rf_we, out_valid, in_ready;
    logic [31:0] rf [32];

    logic        e_save_req, e_restore_req, e_abort, e_out_ready, e_in_valid;
    logic [31:0] e_in_data, e_rf_rdata, e_rf_wdata, e_out_data;
    logic [4:0]  e_rf_raddr, e_rf_waddr, e_out_addr;
    logic        e_busy, e_done, e_rf_we, e_out_valid, e_in_ready;
    logic [31:0] rf_e [32];

    int errors = 0;
    int checks = 0;

    ibex_rf_checkpoint #(.RV32E(1'b0), .DataWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .save_req_i(save_req), .restore_req_i(restore_req),
        .abort_i(abort), .busy_o(busy), .done_o(done), .rf_raddr_o(rf_raddr),
        .rf_rdata_i(rf_rdata), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .rf_we_o(rf_we), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_data_o(out_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data)
    );

    ibex_rf_checkpoint #(.RV32E(1'b1), .DataWidth(32)) dut_e (
        .clk_i(clk), .rst_i(rst), .save_req_i(e_save_req), .restore_req_i(e_restore_req),
        .abort_i(e_abort), .busy_o(e_busy), .done_o(e_done), .rf_raddr_o(e_rf_raddr),
        .rf_rdata_i(e_rf_rdata), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
        .rf_we_o(e_rf_we), .out_valid_o(e_out_valid), .out_ready_i(e_out_ready),
        .out_addr_o(e_out_addr), .out_data_o(e_out_data), .in_valid_i(e_in_valid),
        .in_ready_o(e_in_ready), .in_data_i(e_in_data)
    );

    // Register-file models: asynchronous read, write on the clock edge.
    assign rf_rdata   = rf[rf_raddr];
    assign e_rf_rdata = rf_e[e_rf_raddr];
    always @(posedge clk) if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
    always @(posedge clk) if (e_rf_we && e_rf_waddr != 5'd0) rf_e[e_rf_waddr] <= e_rf_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit restore;
        int pct;         // probability (percent) of ready/valid per cycle
        int abort_at;    // 0: none; else stop after this many transfers
        bit use_rst;     // stop with reset instead of abort
        int exp_xfers;
        int exp_done;    // >0 exact done cycle, 0 done once any cycle, -1 never
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int          xfers, ndone, done_cyc, last_cyc, end_cyc;
        bit          mb, fin, prev_stall, finished;
        logic [4:0]  held_a;
        logic [31:0] held_d, val;
        logic [31:0] exp_rf [32];
        for (int i = 0; i < 32; i++) begin
            val = v.restore ? 32'h5500 + 32'(i) : (v.pct == 100 ? 32'h100 + 32'(i) : $urandom);
            rf[i] <= val;
            exp_rf[i] = val;
        end
        @(posedge clk);
        xfers = 0; ndone = 0; done_cyc = -1; last_cyc = -10; end_cyc = -10;
        mb = 1'b0; fin = 1'b0; prev_stall = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            bit r, stop_now;
            @(posedge clk); #1;
            save_req    = (cyc == 0) && !v.restore;
            restore_req = (cyc == 0) && v.restore;
            r = ($urandom_range(99) < v.pct);
            abort = 1'b0; rst = 1'b0; stop_now = 1'b0;
            if (v.restore) begin
                out_ready = 1'b0;
                in_valid  = r;
                in_data   = 32'hA000 + 32'(xfers + 1);
                if (v.abort_at > 0 && mb && !fin && xfers == v.abort_at - 1) begin
                    in_valid = 1'b1;
                    stop_now = 1'b1;
                    if (v.use_rst) rst = 1'b1; else abort = 1'b1;
                end
            end else begin
                in_valid  = 1'b0;
                out_ready = r;
                if (v.abort_at > 0 && mb && !fin && xfers == v.abort_at) begin
                    out_ready = 1'b0;
                    abort     = 1'b1;
                    stop_now  = 1'b1;
                end
            end
            @(negedge clk);
            chk("busy", 64'(busy), 64'(mb));
            chk("done", 64'(done), 64'(cyc == last_cyc + 1));
            if (done) begin ndone++; done_cyc = cyc; end
            if (v.restore) begin
                chk("in_ready", 64'(in_ready), 64'(mb));
                chk("rf_we", 64'(rf_we), 64'(in_valid && mb));
                if (in_valid && mb) begin
                    chk("rf_waddr", 64'(rf_waddr), 64'(xfers + 1));
                    chk("rf_wdata", 64'(rf_wdata), 64'(in_data));
                    xfers++;
                    if (xfers == 31) begin fin = 1'b1; last_cyc = cyc; end
                end
            end else begin
                chk("in_ready_save", 64'(in_ready), 64'd0);
                if (!mb) chk("out_valid_idle", 64'(out_valid), 64'd0);
                if (out_valid && prev_stall) begin
                    chk("stall_addr", 64'(out_addr), 64'(held_a));
                    chk("stall_data", 64'(out_data), 64'(held_d));
                end
                if (out_valid && out_ready) begin
                    chk("out_addr", 64'(out_addr), 64'(xfers + 1));
                    chk("out_data", 64'(out_data), 64'(exp_rf[xfers + 1]));
                    xfers++;
                    if (xfers == 31) begin fin = 1'b1; last_cyc = cyc; end
                end
                prev_stall = out_valid && !out_ready;
                held_a = out_addr; held_d = out_data;
            end
            if (stop_now) fin = 1'b1;
            if (fin && end_cyc < 0) end_cyc = cyc;
            if (cyc == 0) mb = 1'b1;
            if (fin) mb = 1'b0;
            if (end_cyc >= 0 && cyc == end_cyc + 2) finished = 1'b1;
        end
        chk("finished_in_budget", 64'(finished), 64'd1);
        chk("xfers", 64'(xfers), 64'(v.exp_xfers));
        chk("done_count", 64'(ndone), 64'(v.exp_done < 0 ? 0 : 1));
        if (v.exp_done > 0) chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        if (v.restore)
            for (int i = 1; i < 32; i++)
                chk($sformatf("rf_x%0d", i), 64'(rf[i]),
                    64'(i <= v.exp_xfers ? 32'hA000 + 32'(i) : 32'h5500 + 32'(i)));
        if (v.use_rst) begin
            chk("rst_out_addr", 64'(out_addr), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int nhs, ndone, dcyc, saw_ready;
        rst = 1'b1; save_req = 0; restore_req = 0; abort = 0; out_ready = 0; in_valid = 0; in_data = 0;
        e_save_req = 0; e_restore_req = 0; e_abort = 0; e_out_ready = 0; e_in_valid = 0; e_in_data = 0;
        for (int i = 0; i < 32; i++) begin
            rf[i] <= 32'h0;
            rf_e[i] <= 32'h300 + 32'(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_addr0", 64'(out_addr), 64'd0);
        chk("rst_out_data0", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_raddr", 64'(rf_raddr), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs[0] = '{restore: 1'b0, pct: 100, abort_at: 0, use_rst: 1'b0, exp_xfers: 31, exp_done: 33};
        vecs[1] = '{restore: 1'b0, pct: 55,  abort_at: 0, use_rst: 1'b0, exp_xfers: 31, exp_done: 0};
        vecs[2] = '{restore: 1'b1, pct: 100, abort_at: 0, use_rst: 1'b0, exp_xfers: 31, exp_done: 32};
        vecs[3] = '{restore: 1'b1, pct: 60,  abort_at: 0, use_rst: 1'b0, exp_xfers: 31, exp_done: 0};
        vecs[4] = '{restore: 1'b1, pct: 100, abort_at: 5, use_rst: 1'b0, exp_xfers: 5,  exp_done: -1};
        vecs[5] = '{restore: 1'b1, pct: 100, abort_at: 5, use_rst: 1'b1, exp_xfers: 5,  exp_done: -1};
        vecs[6] = '{restore: 1'b0, pct: 50,  abort_at: 7, use_rst: 1'b0, exp_xfers: 7,  exp_done: -1};
        for (int t = 0; t < 7; t++) run_vec(vecs[t]);

        // Both requests together: save wins; restore pulse mid-save ignored;
        // back-to-back restore accepted in the done cycle, then aborted.
        for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
        @(posedge clk);
        nhs = 0; dcyc = -1; saw_ready = 0;
        for (int c = 0; c < 36; c++) begin
            @(posedge clk); #1;
            save_req    = (c == 0);
            restore_req = (c == 0) || (c == 5) || (c == 33);
            out_ready   = 1'b1;
            in_valid    = 1'b0;
            abort       = (c == 34);
            @(negedge clk);
            if (c <= 32 && in_ready) saw_ready++;
            if (out_valid && out_ready) begin
                chk("both_addr", 64'(out_addr), 64'(nhs + 1));
                chk("both_data", 64'(out_data), 64'(32'h100 + 32'(nhs + 1)));
                nhs++;
            end
            if (done) dcyc = c;
            if (c == 34) chk("b2b_in_ready", 64'(in_ready), 64'd1);
            if (c == 35) begin
                chk("b2b_abort_idle", 64'(busy), 64'd0);
                chk("b2b_abort_nodone", 64'(done), 64'd0);
            end
        end
        chk("both_beats", 64'(nhs), 64'd31);
        chk("both_no_restore", 64'(saw_ready), 64'd0);
        chk("both_done_cycle", 64'(dcyc), 64'd33);
        restore_req = 1'b0; out_ready = 1'b0; abort = 1'b0;

        // RV32E instance: 15 beats, done in cycle 17.
        nhs = 0; ndone = 0; dcyc = -1;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk); #1;
            e_save_req  = (c == 0);
            e_out_ready = 1'b1;
            @(negedge clk);
            if (e_out_valid && e_out_ready) begin
                chk("e_addr", 64'(e_out_addr), 64'(nhs + 1));
                chk("e_data", 64'(e_out_data), 64'(32'h300 + 32'(nhs + 1)));
                nhs++;
            end
            if (e_done) begin ndone++; dcyc = c; end
        end
        chk("e_beats", 64'(nhs), 64'd15);
        chk("e_done_count", 64'(ndone), 64'd1);
        chk("e_done_cycle", 64'(dcyc), 64'd17);
        chk("e_idle", 64'(e_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
